vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Source end of the pixel-coordinate interface: generates 640x480@60 Hz VGA timing from the 50 MHz board clock.
- Drives the x/y pixel coordinates consumed by the game renderer.
- Samples the renderer's returned 10-bit red/green/blue and outputs them to the DAC aligned with registered hsync/vsync/blank.
- Sits between the top level's clock/reset and the VGA DAC pins.

Parameters:
- CLK_DIV, 2, system clocks per pixel (pixel enable period); legal values >= 1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- x  out  10  current horizontal pixel counter, 0..H_TOTAL-1.
- y  out  10  current vertical line counter, 0..V_TOTAL-1.
- pix_en  out  1  one-clk pulse marking a pixel boundary.
- frame_tick  out  1  one-clk pulse at end of frame.
- red  in  10  renderer red for the current (x,y).
- green  in  10  renderer green for the current (x,y).
- blue  in  10  renderer blue for the current (x,y).
- vga_r  out  10  registered, blank-gated red to the DAC.
- vga_g  out  10  registered, blank-gated green to the DAC.
- vga_b  out  10  registered, blank-gated blue to the DAC.
- hsync_n  out  1  horizontal sync, active low.
- vsync_n  out  1  vertical sync, active low.
- blank_n  out  1  low outside the active area.
- vga_clk  out  1  pixel clock to the DAC; high for the second half of each pixel period.

Behaviour:
- Timing constants: H_TOTAL = 800, V_TOTAL = 525 with defaults.
- Pixel enable:
  - div counter 0..CLK_DIV-1 increments every clk.
  - pix_en = 1 when div == CLK_DIV-1.
  - CLK_DIV = 1 gives pix_en constantly high.
- Counters:
  - On pix_en, hcount increments; it wraps H_TOTAL-1 -> 0.
  - On that wrap, vcount increments; it wraps V_TOTAL-1 -> 0.
  - Without pix_en, both counters hold.
- x = hcount and y = vcount, driven directly from registers (no combinational logic on the outputs).
- frame_tick = pix_en & hcount == H_TOTAL-1 & vcount == V_TOTAL-1. It is high for exactly one clk per frame.
- Sync and blank decode from the current counters, registered on pix_en (one-pixel latency):
  - hsync_n = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_n = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank_n = 1 iff hcount < H_ACTIVE & vcount < V_ACTIVE.
- Colour path:
  - On pix_en, vga_r/g/b <= active ? red/green/blue : 0, where active uses the same decode as blank_n.
  - The renderer is combinational from x/y, so colour and sync for a pixel leave together, one pixel period after x/y present it.
- vga_clk = (div >= CLK_DIV/2), registered. With CLK_DIV = 1 it is clk-gated off and tied to 1.
- Reset (asynchronous, any time including mid-line):
  - div = 0, hcount = 0, vcount = 0.
  - hsync_n = 1, vsync_n = 1, blank_n = 0.
  - vga_r/g/b = 0, frame_tick = 0, vga_clk = 0.
  - After release the first pix_en occurs CLK_DIV clks later; the first frame starts at (0,0).
- Simultaneous events:
  - At an h wrap on the last line, both counters wrap in the same pix_en and frame_tick asserts in that clk.
  - There is no other arbitration.
- Counter widths are fixed at 10 bits. Parameters giving H_TOTAL or V_TOTAL > 1024 are illegal; an elaboration check flags them.

Decomposition:
- Package vga_pkg holds the default timing localparams and the derived values:
  - H_TOTAL, H_SYNC_START, H_SYNC_END.
  - V_TOTAL, V_SYNC_START, V_SYNC_END.
  - COORD_W = 10, COLOR_W = 10.
- One sub-module, mod_counter (parameter MOD):
  - Inputs: clk, reset, en. Outputs: count, wrap = en & count == MOD-1.
  - Instantiated for div, hcount (en = pix_en) and vcount (en = hwrap).

Test Plan:
- Release reset, CLK_DIV = 2 -> first pix_en at clk 2; x steps 0,1,2 every 2 clks; line period 1600 clks; frame period 840000 clks; frame_tick pulses once per frame, coincident with x/y wrap to 0/0.
- Run one line -> hsync_n low for exactly 96 pixels, entering the low state one pixel after x = 656 and returning high one pixel after x = 752; blank_n falls one pixel after x = 640.
- Run one frame -> vsync_n low for exactly 2 lines (y = 490, 491, delayed one pixel); blank_n stays 0 for all of y = 480..524.
- Drive red = x, green = y, blue = 10'h3ff from the bench model:
  - At x = 100, y = 200, vga_r = 100 and vga_g = 200 appear one pixel period later.
  - During blanking, vga_r/g/b = 0 regardless of input.
- Assert reset at x = 300, y = 150 mid-pixel -> all outputs reach reset values in the same clk without a clock edge; after release, counting restarts from (0,0).
- CLK_DIV = 1 -> pix_en constantly high; line period 800 clks; vga_clk = 1; sync widths unchanged in pixels.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: default 640x480@60 timing,
// derived totals/sync windows, bus widths and a small window-decode helper.
package vga_pkg;
   localparam int COORD_W = 10;
   localparam int COLOR_W = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
   localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

   // Half-open window test lo <= v < hi, done in int so an end of 1024 does not wrap.
   function automatic logic in_window(input int v, input int lo, input int hi);
      return (v >= lo) && (v < hi);
   endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate interface between the timing generator (master) and the
// combinational renderer (slave) that answers each (x,y) with a colour.
interface vga_timing_gen_if;
   import vga_pkg::*;

   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               pix_en;
   logic               frame_tick;
   logic [COLOR_W-1:0] red;
   logic [COLOR_W-1:0] green;
   logic [COLOR_W-1:0] blue;

   modport master (output x, y, pix_en, frame_tick, input red, green, blue);
   modport slave  (input x, y, pix_en, frame_tick, output red, green, blue);
endinterface

// File: rtl/mod_counter.sv
// Enabled modulo-MOD counter with a wrap strobe that is high in the enabled
// cycle where the count rolls from MOD-1 back to 0.
module mod_counter
   import vga_pkg::*;
#(
   parameter int MOD = 2,
   parameter int W   = COORD_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);
   assign wrap = en && (count == W'(MOD - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel enable, x/y raster counters, and registered
// sync/blank/colour outputs that leave one pixel after x/y present a pixel.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic               clk,
   input  logic               reset,
   vga_timing_gen_if.master   pix,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b,
   output logic               hsync_n,
   output logic               vsync_n,
   output logic               blank_n,
   output logic               vga_clk
);
   localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEGIN    = H_ACTIVE + H_FP;
   localparam int HS_END      = HS_BEGIN + H_SYNC;
   localparam int VS_BEGIN    = V_ACTIVE + V_FP;
   localparam int VS_END      = VS_BEGIN + V_SYNC;
   localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   generate
      if (CLK_DIV < 1 || LINE_LEN > (1 << COORD_W) || FRAME_LINES > (1 << COORD_W)) begin : g_bad_params
         $error("vga_timing_gen: CLK_DIV must be >= 1 and totals must fit the 10-bit counters");
      end
   endgenerate

   logic [DIV_W-1:0]   div;
   logic [COORD_W-1:0] hcount;
   logic [COORD_W-1:0] vcount;
   logic               pix_en;
   logic               hwrap;
   logic               vwrap;
   logic               active;

   mod_counter #(.MOD(CLK_DIV), .W(DIV_W)) u_div (
      .clk(clk), .reset(reset), .en(1'b1), .count(div), .wrap(pix_en)
   );
   mod_counter #(.MOD(LINE_LEN), .W(COORD_W)) u_hcount (
      .clk(clk), .reset(reset), .en(pix_en), .count(hcount), .wrap(hwrap)
   );
   mod_counter #(.MOD(FRAME_LINES), .W(COORD_W)) u_vcount (
      .clk(clk), .reset(reset), .en(hwrap), .count(vcount), .wrap(vwrap)
   );

   // The vertical wrap already implies pix_en on the last pixel of the last line.
   assign pix.x          = hcount;
   assign pix.y          = vcount;
   assign pix.pix_en     = pix_en;
   assign pix.frame_tick = vwrap;

   assign active = (int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE);

   // Output stage: decode of the current pixel, captured at its closing pix_en.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync_n <= 1'b1;
         vsync_n <= 1'b1;
         blank_n <= 1'b0;
         vga_r   <= '0;
         vga_g   <= '0;
         vga_b   <= '0;
      end else if (pix_en) begin
         hsync_n <= !in_window(int'(hcount), HS_BEGIN, HS_END);
         vsync_n <= !in_window(int'(vcount), VS_BEGIN, VS_END);
         blank_n <= active;
         vga_r   <= active ? pix.red   : '0;
         vga_g   <= active ? pix.green : '0;
         vga_b   <= active ? pix.blue  : '0;
      end
   end

   generate
      if (CLK_DIV == 1) begin : g_vclk_tied
         assign vga_clk = 1'b1;
      end else begin : g_vclk_reg
         // Registering the decode of the next divider value keeps the flop in
         // step with the live divider: high for the second half of each pixel.
         logic [DIV_W-1:0] div_next;
         assign div_next = pix_en ? '0 : div + DIV_W'(1);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               vga_clk <= 1'b0;
            end else begin
               vga_clk <= (int'(div_next) >= CLK_DIV / 2);
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-raster instances (CLK_DIV 2 and 1)
// compared every cycle against an arithmetic raster model, plus pinned values.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 10, VF = 2, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int HSS = HA + HF, HSE = HA + HF + HS;
   localparam int VSS = VA + VF, VSE = VA + VF + VS;
   localparam int FRAME_PIX = HT * VT;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [COLOR_W-1:0] key_r, key_g, key_b;
   logic checking = 1'b0;
   logic stats_on = 1'b0;
   int tests = 0;
   int fails = 0;
   int t = 0;

   logic [COLOR_W-1:0] r2, g2, b2, r1, g1, b1;
   logic hs2, vs2, bl2, vc2, hs1, vs1, bl1, vc1;

   vga_timing_gen_if if2 ();
   vga_timing_gen_if if1 ();

   assign if2.red   = if2.x ^ key_r;
   assign if2.green = if2.y ^ key_g;
   assign if2.blue  = key_b;
   assign if1.red   = if1.x ^ key_r;
   assign if1.green = if1.y ^ key_g;
   assign if1.blue  = key_b;

   vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u2 (
      .clk(clk), .reset(reset), .pix(if2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
      .hsync_n(hs2), .vsync_n(vs2), .blank_n(bl2), .vga_clk(vc2)
   );
   vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u1 (
      .clk(clk), .reset(reset), .pix(if1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
      .hsync_n(hs1), .vsync_n(vs1), .blank_n(bl1), .vga_clk(vc1)
   );

   always #5 clk = ~clk;

   // Clock edges seen since reset was last released.
   always @(posedge clk or posedge reset) begin
      if (reset) t <= 0;
      else       t <= t + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
      end
   endtask

   // Raster model: after t edges, n = t/d pixels are complete; registered
   // outputs describe pixel n-1, or reset values when no pixel has closed.
   task automatic check_dut(input string tag, input int d, input int x, input int y,
                            input int pe, input int ft, input int r, input int g, input int b,
                            input int hs, input int vs, input int bl, input int vc);
      int n, h, v, ph, pv;
      int e_hs, e_vs, e_bl, e_r, e_g, e_b, e_pe, e_ft, e_vc;
      logic act;
      n = t / d;
      h = n % HT;
      v = (n / HT) % VT;
      e_hs = 1; e_vs = 1; e_bl = 0; e_r = 0; e_g = 0; e_b = 0;
      if (n > 0) begin
         ph = (n - 1) % HT;
         pv = ((n - 1) / HT) % VT;
         act = (ph < HA) && (pv < VA);
         e_hs = (ph >= HSS && ph < HSE) ? 0 : 1;
         e_vs = (pv >= VSS && pv < VSE) ? 0 : 1;
         e_bl = act ? 1 : 0;
         e_r = act ? int'(10'(ph) ^ key_r) : 0;
         e_g = act ? int'(10'(pv) ^ key_g) : 0;
         e_b = act ? int'(key_b) : 0;
      end
      e_pe = ((t % d) == d - 1) ? 1 : 0;
      e_ft = (e_pe == 1 && h == HT - 1 && v == VT - 1) ? 1 : 0;
      e_vc = (d == 1) ? 1 : (((t % d) >= d / 2) ? 1 : 0);
      check({tag, "_x"}, x, h);
      check({tag, "_y"}, y, v);
      check({tag, "_pix_en"}, pe, e_pe);
      check({tag, "_frame_tick"}, ft, e_ft);
      check({tag, "_hsync_n"}, hs, e_hs);
      check({tag, "_vsync_n"}, vs, e_vs);
      check({tag, "_blank_n"}, bl, e_bl);
      check({tag, "_vga_r"}, r, e_r);
      check({tag, "_vga_g"}, g, e_g);
      check({tag, "_vga_b"}, b, e_b);
      check({tag, "_vga_clk"}, vc, e_vc);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check_dut("d2", 2, int'(if2.x), int'(if2.y), int'(if2.pix_en), int'(if2.frame_tick),
                   int'(r2), int'(g2), int'(b2), int'(hs2), int'(vs2), int'(bl2), int'(vc2));
         check_dut("d1", 1, int'(if1.x), int'(if1.y), int'(if1.pix_en), int'(if1.frame_tick),
                   int'(r1), int'(g1), int'(b1), int'(hs1), int'(vs1), int'(bl1), int'(vc1));
      end
   end

   // Per-frame tallies from the first release, checked against hand counts.
   int hs_low2 = 0, vs_low2 = 0, bl_hi2 = 0, ft_cnt2 = 0, ft_first2 = -1;
   int hs_low1 = 0, vs_low1 = 0, bl_hi1 = 0, ft_cnt1 = 0, ft_first1 = -1;
   always @(negedge clk) begin
      if (stats_on && !reset) begin
         if (t < 2 * FRAME_PIX) begin
            hs_low2 <= hs_low2 + (hs2 ? 0 : 1);
            vs_low2 <= vs_low2 + (vs2 ? 0 : 1);
            bl_hi2  <= bl_hi2 + (bl2 ? 1 : 0);
         end
         if (t < FRAME_PIX) begin
            hs_low1 <= hs_low1 + (hs1 ? 0 : 1);
            vs_low1 <= vs_low1 + (vs1 ? 0 : 1);
            bl_hi1  <= bl_hi1 + (bl1 ? 1 : 0);
         end
         if (t < 4 * FRAME_PIX && if2.frame_tick) begin
            ft_cnt2 <= ft_cnt2 + 1;
            if (ft_first2 < 0) ft_first2 <= t;
         end
         if (t < 2 * FRAME_PIX && if1.frame_tick) begin
            ft_cnt1 <= ft_cnt1 + 1;
            if (ft_first1 < 0) ft_first1 <= t;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      key_r = '0;
      key_g = '0;
      key_b = 10'h3ff;
      reset = 1'b1;
      checking = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_x2", int'(if2.x), 0);
      check("rst_hsync2", int'(hs2), 1);
      check("rst_blank2", int'(bl2), 0);
      check("rst_vga_clk2", int'(vc2), 0);

      @(posedge clk);
      #2 reset = 1'b0;
      stats_on = 1'b1;

      cnt = 0;
      while (if1.x != 10'd1 && cnt < 100) begin @(negedge clk); cnt++; end
      check("first_x_step_d1", t, 1);
      cnt = 0;
      while (if2.x != 10'd1 && cnt < 100) begin @(negedge clk); cnt++; end
      check("first_x_step_d2", t, 2);
      cnt = 0;
      while (if1.y != 10'd1 && cnt < 200) begin @(negedge clk); cnt++; end
      check("line_period_d1", t, 24);
      cnt = 0;
      while (if2.y != 10'd1 && cnt < 200) begin @(negedge clk); cnt++; end
      check("line_period_d2", t, 48);

      // Active pixel (10,5): colour appears one pixel after it is presented.
      cnt = 0;
      while (!(if2.x == 10'd10 && if2.y == 10'd5 && if2.pix_en) && cnt < 1000) begin
         @(negedge clk); cnt++;
      end
      check("wait_px_10_5", (cnt < 1000) ? 1 : 0, 1);
      @(posedge clk); #1;
      check("px_10_5_vga_r", int'(r2), 10);
      check("px_10_5_vga_g", int'(g2), 5);
      check("px_10_5_vga_b", int'(b2), 1023);
      check("px_10_5_blank_n", int'(bl2), 1);

      // Pixel (19,12) lies in both sync windows and in blanking.
      cnt = 0;
      while (!(if2.x == 10'd19 && if2.y == 10'd12 && if2.pix_en) && cnt < 1000) begin
         @(negedge clk); cnt++;
      end
      check("wait_px_19_12", (cnt < 1000) ? 1 : 0, 1);
      @(posedge clk); #1;
      check("px_19_12_hsync_n", int'(hs2), 0);
      check("px_19_12_vsync_n", int'(vs2), 0);
      check("px_19_12_blank_n", int'(bl2), 0);
      check("px_19_12_vga_b", int'(b2), 0);

      cnt = 0;
      while (t < 4 * FRAME_PIX + 4 && cnt < 4000) begin @(negedge clk); cnt++; end
      @(negedge clk);
      check("hsync_low_clks_d2", hs_low2, 96);
      check("vsync_low_clks_d2", vs_low2, 96);
      check("blank_high_clks_d2", bl_hi2, 320);
      check("first_frame_tick_d2", ft_first2, 767);
      check("frame_ticks_d2", ft_cnt2, 2);
      check("hsync_low_clks_d1", hs_low1, 48);
      check("vsync_low_clks_d1", vs_low1, 48);
      check("blank_high_clks_d1", bl_hi1, 160);
      check("first_frame_tick_d1", ft_first1, 383);
      check("frame_ticks_d1", ft_cnt1, 2);

      // Asynchronous reset in the middle of an active pixel at (7,5).
      cnt = 0;
      while (!(if2.x == 10'd7 && if2.y == 10'd5 && if2.pix_en) && cnt < 1000) begin
         @(negedge clk); cnt++;
      end
      check("wait_px_7_5", (cnt < 1000) ? 1 : 0, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_x2", int'(if2.x), 0);
      check("async_rst_y2", int'(if2.y), 0);
      check("async_rst_vga_r2", int'(r2), 0);
      check("async_rst_blank2", int'(bl2), 0);
      check("async_rst_hsync2", int'(hs2), 1);
      check("async_rst_vga_clk2", int'(vc2), 0);
      check("async_rst_x1", int'(if1.x), 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      cnt = 0;
      while (if2.x != 10'd1 && cnt < 100) begin @(negedge clk); cnt++; end
      check("restart_x_step_d2", t, 2);

      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(20, 1200)) @(posedge clk);
         #($urandom_range(1, 4)) reset = 1'b1;
         #1;
         check("rand_rst_x2", int'(if2.x), 0);
         check("rand_rst_vsync2", int'(vs2), 1);
         key_r = 10'($urandom);
         key_g = 10'($urandom);
         key_b = 10'($urandom);
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #2 reset = 1'b0;
      end
      repeat (300) @(posedge clk);
      @(negedge clk);
      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
